// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial LSB-first adder built from two half adders and a carry flop
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   start  request, sampled only in IDLE
//   A, B   WIDTH-bit operands, captured on the accepting edge
//   cin    carry-in, captured on the accepting edge
//   busy   high while bits are being shifted (state == SHIFT)
//   done   one-cycle pulse, sum/carry just updated
//   sum    registered WIDTH-bit result, held between completions
//   carry  registered carry-out, held between completions

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] ps;
  logic             c;
  logic [CW-1:0]    cnt;

  // Full add of the current LSB from two half-adder stages.
  logic h1, g1, s, g2, cnext;

  always_comb begin
    h1    = ra[0] ^ rb[0];
    g1    = ra[0] & rb[0];
    s     = h1 ^ c;
    g2    = h1 & c;
    cnext = g1 | g2;
  end

  assign busy = (state == SHIFT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ra    <= '0;
      rb    <= '0;
      ps    <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      done  <= 1'b0;
      sum   <= '0;
      carry <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ra    <= A;
            rb    <= B;
            c     <= cin;
            ps    <= '0;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          c   <= cnext;
          // New result bit enters at the MSB so after WIDTH shifts bit 0 lines up.
          ps  <= {s, ps[WIDTH-1:1]};
          ra  <= ra >> 1;
          rb  <= rb >> 1;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            sum   <= {s, ps[WIDTH-1:1]};
            carry <= cnext;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed and random checks of serial_adder at WIDTH 8 and 13

module tb_serial_adder;

  logic clk = 1'b0;
  logic rst;

  logic        start8, cin8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, carry8;
  logic [7:0]  sum8;

  logic        start13, cin13;
  logic [12:0] a13, b13;
  logic        busy13, done13, carry13;
  logic [12:0] sum13;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .carry(carry8)
  );

  serial_adder #(.WIDTH(13)) u_dut13 (
    .clk(clk), .rst(rst), .start(start13), .A(a13), .B(b13), .cin(cin13),
    .busy(busy13), .done(done13), .sum(sum13), .carry(carry13)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic dn(input int w);
    return (w == 8) ? done8 : done13;
  endfunction

  function automatic logic bz(input int w);
    return (w == 8) ? busy8 : busy13;
  endfunction

  function automatic logic [32:0] res(input int w);
    return (w == 8) ? {24'd0, carry8, sum8} : {19'd0, carry13, sum13};
  endfunction

  task automatic drive(input int w, input logic [31:0] a, input logic [31:0] b,
                       input logic ci, input logic st);
    if (w == 8) begin
      a8 = a[7:0]; b8 = b[7:0]; cin8 = ci; start8 = st;
    end else begin
      a13 = a[12:0]; b13 = b[12:0]; cin13 = ci; start13 = st;
    end
  endtask

  // One complete operation: accept, count cycles to done, check result and pulse width.
  task automatic run(input int w, input logic [31:0] a, input logic [31:0] b,
                     input logic ci, input logic [32:0] exp, input string tag);
    int cyc, bcyc;
    @(negedge clk);
    drive(w, a, b, ci, 1'b1);
    @(negedge clk);
    drive(w, 32'hDEAD_BEEF, 32'h1234_5678, ~ci, 1'b0);
    cyc = 0;
    bcyc = 0;
    while (!dn(w) && cyc < 64) begin
      if (bz(w)) bcyc++;
      @(negedge clk);
      cyc++;
    end
    check({tag, ".latency"}, cyc, w);
    check({tag, ".busy_cycles"}, bcyc, w);
    check({tag, ".result"}, res(w), exp);
    check({tag, ".busy_at_done"}, bz(w), 1'b0);
    @(negedge clk);
    check({tag, ".done_one_cycle"}, dn(w), 1'b0);
  endtask

  initial begin
    int cyc, ndone, stable_err, gap;
    logic [7:0] bta [0:3];
    logic [7:0] btb [0:3];
    logic [8:0] btexp [0:3];
    logic [31:0] ra, rb;
    logic rc;
    logic [32:0] e;

    rst = 1'b1;
    drive(8, 0, 0, 0, 0);
    drive(13, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check("reset.busy", busy8, 1'b0);
    check("reset.done", done8, 1'b0);
    check("reset.result", {carry8, sum8}, 9'h000);
    rst = 1'b0;

    run(8, 32'h3C, 32'h0F, 1'b0, 33'h04B, "add_3c_0f");
    run(8, 32'hFF, 32'h01, 1'b0, 33'h100, "add_ff_01");
    run(8, 32'hFF, 32'hFF, 1'b1, 33'h1FF, "add_ff_ff_c");
    run(8, 32'h00, 32'h00, 1'b1, 33'h001, "add_0_0_c");

    // start while busy must be ignored
    @(negedge clk);
    drive(8, 32'h10, 32'h20, 1'b0, 1'b1);
    @(negedge clk);
    drive(8, 0, 0, 0, 0);
    cyc = 0;
    ndone = 0;
    while (cyc < 20) begin
      if (cyc == 3) drive(8, 32'hAA, 32'h55, 1'b1, 1'b1);
      else start8 = 1'b0;
      if (done8) begin
        ndone++;
        check("ignore.result", {carry8, sum8}, 9'h030);
        check("ignore.latency", cyc, 8);
      end
      @(negedge clk);
      cyc++;
    end
    check("ignore.done_count", ndone, 1);
    check("ignore.idle_after", busy8, 1'b0);

    // reset mid-operation aborts
    @(negedge clk);
    drive(8, 32'h3C, 32'h0F, 1'b0, 1'b1);
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort.busy", busy8, 1'b0);
    check("abort.result", {carry8, sum8}, 9'h000);
    ndone = 0;
    repeat (12) begin
      if (done8) ndone++;
      @(negedge clk);
    end
    check("abort.no_done", ndone, 0);
    run(8, 32'h01, 32'h01, 1'b0, 33'h002, "after_abort");

    // back-to-back with start held high
    bta[0] = 8'h12; btb[0] = 8'h34; btexp[0] = 9'h046;
    bta[1] = 8'hF0; btb[1] = 8'h20; btexp[1] = 9'h110;
    bta[2] = 8'h7F; btb[2] = 8'h01; btexp[2] = 9'h080;
    bta[3] = 8'hC8; btb[3] = 8'h64; btexp[3] = 9'h12C;
    stable_err = 0;
    @(negedge clk);
    drive(8, {24'd0, bta[0]}, {24'd0, btb[0]}, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k < 3) drive(8, {24'd0, bta[k+1]}, {24'd0, btb[k+1]}, 1'b0, 1'b1);
      else start8 = 1'b0;
      gap = 0;
      while (!done8 && gap < 64) begin
        if (k > 0 && {carry8, sum8} !== btexp[k-1]) stable_err++;
        @(negedge clk);
        gap++;
      end
      check($sformatf("b2b%0d.latency", k), gap, 8);
      check($sformatf("b2b%0d.result", k), {carry8, sum8}, btexp[k]);
    end
    check("b2b.sum_stable", stable_err, 0);
    @(negedge clk);
    check("b2b.done_low", done8, 1'b0);

    // random regression at both widths
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom & 32'hFF;
      rb = $urandom & 32'hFF;
      rc = 1'($urandom);
      e = {25'd0, ra[7:0]} + {25'd0, rb[7:0]} + {32'd0, rc};
      run(8, ra, rb, rc, e, "rand8");
    end
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom & 32'h1FFF;
      rb = $urandom & 32'h1FFF;
      rc = 1'($urandom);
      e = {20'd0, ra[12:0]} + {20'd0, rb[12:0]} + {32'd0, rc};
      run(13, ra, rb, rc, e, "rand13");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
